// File: rtl/pixel_arbiter_if.sv
// Beat-level bus between the three pixel requesters, the arbiter and the
// packet generator. The arbiter sits on the slave side.
interface pixel_arbiter_if #(
    parameter int COORD_W = 8,
    parameter int COLOR_W = 3
);
    logic               fh_valid;
    logic               fh_ready;
    logic [COORD_W-1:0] fh_x;
    logic [COORD_W-1:0] fh_y;
    logic [COLOR_W-1:0] fh_color;

    logic               fl_valid;
    logic               fl_ready;
    logic [COORD_W-1:0] fl_x;
    logic [COORD_W-1:0] fl_y;
    logic [COLOR_W-1:0] fl_color;
    logic               fl_last;

    logic               rs_valid;
    logic               rs_ready;
    logic [COORD_W-1:0] rs_x;
    logic [COORD_W-1:0] rs_y;
    logic [COLOR_W-1:0] rs_color;

    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic [COLOR_W-1:0] out_color;
    logic [1:0]         out_src;
    logic               busy;

    modport slave (
        input  fh_valid, fh_x, fh_y, fh_color,
        input  fl_valid, fl_x, fl_y, fl_color, fl_last,
        input  rs_valid, rs_x, rs_y, rs_color,
        input  out_ready,
        output fh_ready, fl_ready, rs_ready,
        output out_valid, out_x, out_y, out_color, out_src, busy
    );

    modport master (
        output fh_valid, fh_x, fh_y, fh_color,
        output fl_valid, fl_x, fl_y, fl_color, fl_last,
        output rs_valid, rs_x, rs_y, rs_color,
        output out_ready,
        input  fh_ready, fl_ready, rs_ready,
        input  out_valid, out_x, out_y, out_color, out_src, busy
    );
endinterface

// File: rtl/pixel_arbiter.sv
// Fixed-priority pixel-write arbiter with fill-burst locking, freehand
// starvation protection and a one-entry registered output stage.
module pixel_arbiter #(
    parameter int COORD_W      = 8,
    parameter int COLOR_W      = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    pixel_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_FILL_LOCK = 1'b1
    } state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [1:0] SRC_NONE   = 2'b00;
    localparam logic [1:0] SRC_FH     = 2'b01;
    localparam logic [1:0] SRC_FL     = 2'b10;
    localparam logic [1:0] SRC_RS     = 2'b11;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [7:0]         starve_cnt_r;
    logic [7:0]         starve_nxt_s;
    logic               load_en_s;
    logic [1:0]         grant_s;
    logic [COORD_W-1:0] sel_x_s;
    logic [COORD_W-1:0] sel_y_s;
    logic [COLOR_W-1:0] sel_color_s;

    logic               out_valid_r;
    logic [COORD_W-1:0] out_x_r;
    logic [COORD_W-1:0] out_y_r;
    logic [COLOR_W-1:0] out_color_r;
    logic [1:0]         out_src_r;

    // Arbitration: pick the single winner for this cycle (none while in reset or stalled)
    always_comb begin
        load_en_s = !out_valid_r || bus.out_ready;
        grant_s   = SRC_NONE;
        if (rst || !load_en_s) begin
            grant_s = SRC_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.fh_valid && (starve_cnt_r == STARVE_MAX)) begin
                        grant_s = SRC_FH;
                    end else if (bus.rs_valid) begin
                        grant_s = SRC_RS;
                    end else if (bus.fl_valid) begin
                        grant_s = SRC_FL;
                    end else if (bus.fh_valid) begin
                        grant_s = SRC_FH;
                    end else begin
                        grant_s = SRC_NONE;
                    end
                end
                ST_FILL_LOCK: begin
                    if (bus.fl_valid) begin
                        grant_s = SRC_FL;
                    end else begin
                        grant_s = SRC_NONE;
                    end
                end
                default: grant_s = SRC_NONE;
            endcase
        end
    end

    assign bus.fh_ready = (grant_s == SRC_FH);
    assign bus.fl_ready = (grant_s == SRC_FL);
    assign bus.rs_ready = (grant_s == SRC_RS);

    // Burst lock state and starvation counter update
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if ((grant_s == SRC_FL) && !bus.fl_last) begin
                    state_nxt_s = ST_FILL_LOCK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL_LOCK: begin
                if ((grant_s == SRC_FL) && bus.fl_last) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FILL_LOCK;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        // The lock freezes the count so freehand keeps its claim for after the burst
        if (!bus.fh_valid || (grant_s == SRC_FH)) begin
            starve_nxt_s = 8'd0;
        end else if ((state_r == ST_IDLE) && (starve_cnt_r != STARVE_MAX)) begin
            starve_nxt_s = starve_cnt_r + 8'd1;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Payload mux for the granted requester
    always_comb begin
        sel_x_s     = '0;
        sel_y_s     = '0;
        sel_color_s = '0;
        case (grant_s)
            SRC_FH: begin
                sel_x_s     = bus.fh_x;
                sel_y_s     = bus.fh_y;
                sel_color_s = bus.fh_color;
            end
            SRC_FL: begin
                sel_x_s     = bus.fl_x;
                sel_y_s     = bus.fl_y;
                sel_color_s = bus.fl_color;
            end
            SRC_RS: begin
                sel_x_s     = bus.rs_x;
                sel_y_s     = bus.rs_y;
                sel_color_s = bus.rs_color;
            end
            default: begin
                sel_x_s     = '0;
                sel_y_s     = '0;
                sel_color_s = '0;
            end
        endcase
    end

    // State registers and the one-entry output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= 8'd0;
            out_valid_r  <= 1'b0;
            out_x_r      <= '0;
            out_y_r      <= '0;
            out_color_r  <= '0;
            out_src_r    <= SRC_NONE;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            if (load_en_s) begin
                out_valid_r <= (grant_s != SRC_NONE);
                // out_src keeps the last source when the stage drains
                if (grant_s != SRC_NONE) begin
                    out_x_r     <= sel_x_s;
                    out_y_r     <= sel_y_s;
                    out_color_r <= sel_color_s;
                    out_src_r   <= grant_s;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_x     = out_x_r;
    assign bus.out_y     = out_y_r;
    assign bus.out_color = out_color_r;
    assign bus.out_src   = out_src_r;
    assign bus.busy      = out_valid_r || (state_r == ST_FILL_LOCK);

endmodule

// File: tb/tb_pixel_arbiter.sv
// Directed scenarios plus a randomized run against a behavioural model of
// the arbiter's grant rules (STARVE_LIMIT = 3).
module tb_pixel_arbiter;

    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pixel_arbiter_if #(.COORD_W(8), .COLOR_W(3)) bus ();

    pixel_arbiter #(.COORD_W(8), .COLOR_W(3), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // reference model state
    bit       m_ov;
    bit       m_lock;
    int       m_cnt;
    bit [7:0] m_x;
    bit [7:0] m_y;
    bit [2:0] m_c;
    bit [1:0] m_src;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fh_valid = 1'b0; bus.fh_x = 8'd0; bus.fh_y = 8'd0; bus.fh_color = 3'd0;
        bus.fl_valid = 1'b0; bus.fl_x = 8'd0; bus.fl_y = 8'd0; bus.fl_color = 3'd0;
        bus.fl_last  = 1'b0;
        bus.rs_valid = 1'b0; bus.rs_x = 8'd0; bus.rs_y = 8'd0; bus.rs_color = 3'd0;
    endtask

    task automatic idle_cycle();
        clear_inputs();
        bus.out_ready = 1'b1;
        tick();
    endtask

    function automatic bit [2:0] rdy();
        return {bus.fh_ready, bus.fl_ready, bus.rs_ready};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.fh_valid = 1'b1; bus.fl_valid = 1'b1; bus.rs_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (rdy() !== 3'b000) begin
            errors++; $display("FAIL reset_ready_gate: got %b want 000", rdy());
        end
        tick(); tick();
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_src, bus.busy, bus.out_x} !== {1'b0, 2'b00, 1'b0, 8'd0}) begin
            errors++; $display("FAIL reset_outputs: got v=%b src=%b busy=%b x=%0d want 0/00/0/0",
                               bus.out_valid, bus.out_src, bus.busy, bus.out_x);
        end
        tick();
        checks++;
        if ({rdy(), bus.out_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_idle: got rdy=%b v=%b want 000/0", rdy(), bus.out_valid);
        end
    endtask

    task automatic test_single_freehand();
        idle_cycle();
        bus.fh_valid = 1'b1; bus.fh_x = 8'd10; bus.fh_y = 8'd20; bus.fh_color = 3'd5;
        #1;
        checks++;
        if (rdy() !== 3'b100) begin
            errors++; $display("FAIL single_fh_ready: got %b want 100", rdy());
        end
        tick();
        bus.fh_valid = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_color, bus.out_src} !==
            {1'b1, 8'd10, 8'd20, 3'd5, 2'b01}) begin
            errors++; $display("FAIL single_fh_out: got v=%b x=%0d y=%0d c=%0d src=%b want 1/10/20/5/01",
                               bus.out_valid, bus.out_x, bus.out_y, bus.out_color, bus.out_src);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_src} !== {1'b0, 2'b01}) begin
            errors++; $display("FAIL single_fh_drain: got v=%b src=%b want 0/01", bus.out_valid, bus.out_src);
        end
    endtask

    task automatic test_fill_burst();
        idle_cycle();
        for (int k = 0; k < 4; k++) begin
            bus.fl_valid = 1'b1; bus.fl_x = 8'(k); bus.fl_y = 8'(k + 50); bus.fl_color = 3'd2;
            bus.fl_last = (k == 3);
            if (k >= 1) begin
                bus.rs_valid = 1'b1; bus.rs_x = 8'd100; bus.rs_y = 8'd101; bus.rs_color = 3'd7;
            end
            #1;
            checks++;
            if (rdy() !== 3'b010) begin
                errors++; $display("FAIL fill_beat%0d_ready: got %b want 010", k, rdy());
            end
            if (k >= 1) begin
                checks++;
                if ({bus.out_valid, bus.out_x, bus.out_src, bus.busy} !== {1'b1, 8'(k - 1), 2'b10, 1'b1}) begin
                    errors++; $display("FAIL fill_beat%0d_out: got v=%b x=%0d src=%b busy=%b want 1/%0d/10/1",
                                       k, bus.out_valid, bus.out_x, bus.out_src, bus.busy, k - 1);
                end
            end
            tick();
        end
        bus.fl_valid = 1'b0; bus.fl_last = 1'b0;
        #1;
        checks++;
        if ({rdy(), bus.out_x, bus.out_src, bus.busy} !== {3'b001, 8'd3, 2'b10, 1'b1}) begin
            errors++; $display("FAIL fill_release: got rdy=%b x=%0d src=%b busy=%b want 001/3/10/1",
                               rdy(), bus.out_x, bus.out_src, bus.busy);
        end
        tick();
        bus.rs_valid = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_color, bus.out_src} !==
            {1'b1, 8'd100, 8'd101, 3'd7, 2'b11}) begin
            errors++; $display("FAIL fill_then_restore: got v=%b x=%0d y=%0d c=%0d src=%b want 1/100/101/7/11",
                               bus.out_valid, bus.out_x, bus.out_y, bus.out_color, bus.out_src);
        end
    endtask

    task automatic test_priority();
        idle_cycle();
        bus.fh_valid = 1'b1; bus.fh_x = 8'd1;
        bus.fl_valid = 1'b1; bus.fl_x = 8'd2; bus.fl_last = 1'b1;
        bus.rs_valid = 1'b1; bus.rs_x = 8'd3;
        #1;
        checks++;
        if (rdy() !== 3'b001) begin
            errors++; $display("FAIL prio_first: got %b want 001", rdy());
        end
        tick();
        bus.rs_valid = 1'b0;
        #1;
        checks++;
        if ({rdy(), bus.out_src, bus.out_x} !== {3'b010, 2'b11, 8'd3}) begin
            errors++; $display("FAIL prio_second: got rdy=%b src=%b x=%0d want 010/11/3", rdy(), bus.out_src, bus.out_x);
        end
        tick();
        bus.fl_valid = 1'b0;
        #1;
        checks++;
        if ({rdy(), bus.out_src, bus.out_x} !== {3'b100, 2'b10, 8'd2}) begin
            errors++; $display("FAIL prio_third: got rdy=%b src=%b x=%0d want 100/10/2", rdy(), bus.out_src, bus.out_x);
        end
        tick();
        bus.fh_valid = 1'b0;
        #1;
        checks++;
        if ({bus.out_src, bus.out_x} !== {2'b01, 8'd1}) begin
            errors++; $display("FAIL prio_fh_out: got src=%b x=%0d want 01/1", bus.out_src, bus.out_x);
        end
    endtask

    task automatic test_starvation();
        idle_cycle();
        bus.rs_valid = 1'b1; bus.rs_x = 8'd9;
        bus.fh_valid = 1'b1; bus.fh_x = 8'd4;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if (rdy() !== ((c == LIMIT + 1) ? 3'b100 : 3'b001)) begin
                errors++; $display("FAIL starve_cycle%0d: got %b want %b", c, rdy(),
                                   (c == LIMIT + 1) ? 3'b100 : 3'b001);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        idle_cycle();
        bus.fh_valid = 1'b1; bus.fh_x = 8'd33; bus.fh_y = 8'd44; bus.fh_color = 3'd6;
        #1;
        checks++;
        if (rdy() !== 3'b100) begin
            errors++; $display("FAIL bp_load: got %b want 100", rdy());
        end
        tick();
        bus.out_ready = 1'b0;
        bus.fh_x = 8'd55; bus.fh_y = 8'd66; bus.fh_color = 3'd2;
        bus.rs_valid = 1'b1; bus.rs_x = 8'd77; bus.rs_y = 8'd88; bus.rs_color = 3'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rdy(), bus.out_valid, bus.out_x, bus.out_y, bus.out_color, bus.out_src} !==
                {3'b000, 1'b1, 8'd33, 8'd44, 3'd6, 2'b01}) begin
                errors++; $display("FAIL bp_hold%0d: got rdy=%b v=%b x=%0d y=%0d c=%0d src=%b want 000/1/33/44/6/01",
                                   i, rdy(), bus.out_valid, bus.out_x, bus.out_y, bus.out_color, bus.out_src);
            end
            tick();
        end
        // stalled cycles kept the starvation count running, so freehand now outranks restore
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (rdy() !== 3'b100) begin
            errors++; $display("FAIL bp_release: got %b want 100", rdy());
        end
        tick();
        bus.fh_valid = 1'b0;
        #1;
        checks++;
        if ({rdy(), bus.out_x, bus.out_src} !== {3'b001, 8'd55, 2'b01}) begin
            errors++; $display("FAIL bp_after: got rdy=%b x=%0d src=%b want 001/55/01", rdy(), bus.out_x, bus.out_src);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if ({bus.out_x, bus.out_src} !== {8'd77, 2'b11}) begin
            errors++; $display("FAIL bp_restore: got x=%0d src=%b want 77/11", bus.out_x, bus.out_src);
        end
    endtask

    task automatic test_reset_mid_burst();
        idle_cycle();
        bus.fl_valid = 1'b1; bus.fl_x = 8'd9; bus.fl_last = 1'b0;
        #1;
        checks++;
        if (rdy() !== 3'b010) begin
            errors++; $display("FAIL rst_burst_start: got %b want 010", rdy());
        end
        tick();
        bus.fl_valid = 1'b0;
        bus.fh_valid = 1'b1; bus.fh_x = 8'd1; bus.fh_y = 8'd2; bus.fh_color = 3'd3;
        #1;
        checks++;
        if ({rdy(), bus.busy} !== 4'b0001) begin
            errors++; $display("FAIL rst_burst_locked: got rdy=%b busy=%b want 000/1", rdy(), bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rdy(), bus.out_valid, bus.busy} !== 5'b00000) begin
            errors++; $display("FAIL rst_burst_clear: got rdy=%b v=%b busy=%b want 000/0/0", rdy(), bus.out_valid, bus.busy);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rdy() !== 3'b100) begin
            errors++; $display("FAIL rst_burst_fh: got %b want 100", rdy());
        end
        tick();
        bus.fh_valid = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_x, bus.out_src} !== {1'b1, 8'd1, 2'b01}) begin
            errors++; $display("FAIL rst_burst_out: got v=%b x=%0d src=%b want 1/1/01", bus.out_valid, bus.out_x, bus.out_src);
        end
        clear_inputs();
    endtask

    // Grant rule from the arbitration description: which source wins this cycle
    function automatic bit [1:0] model_grant();
        if (m_ov && !bus.out_ready) return 2'd0;
        if (m_lock) return bus.fl_valid ? 2'd2 : 2'd0;
        if (bus.fh_valid && m_cnt == LIMIT) return 2'd1;
        if (bus.rs_valid) return 2'd3;
        if (bus.fl_valid) return 2'd2;
        if (bus.fh_valid) return 2'd1;
        return 2'd0;
    endfunction

    task automatic test_random();
        bit       fh_pend = 1'b0;
        bit       fl_pend = 1'b0;
        bit       rs_pend = 1'b0;
        bit [1:0] g;
        bit [2:0] exp_rdy;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ov = 1'b0; m_lock = 1'b0; m_cnt = 0;
        m_x = 8'd0; m_y = 8'd0; m_c = 3'd0; m_src = 2'd0;
        for (int n = 0; n < 400; n++) begin
            if (!fh_pend) begin
                bus.fh_valid = ($urandom_range(0, 99) < 55);
                bus.fh_x = 8'($urandom); bus.fh_y = 8'($urandom); bus.fh_color = 3'($urandom);
            end
            if (!fl_pend) begin
                bus.fl_valid = ($urandom_range(0, 99) < 45);
                bus.fl_x = 8'($urandom); bus.fl_y = 8'($urandom); bus.fl_color = 3'($urandom);
                bus.fl_last = ($urandom_range(0, 3) == 0);
            end
            if (!rs_pend) begin
                bus.rs_valid = ($urandom_range(0, 99) < 35);
                bus.rs_x = 8'($urandom); bus.rs_y = 8'($urandom); bus.rs_color = 3'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = model_grant();
            exp_rdy = {g == 2'd1, g == 2'd2, g == 2'd3};
            checks++;
            if (rdy() !== exp_rdy) begin
                errors++; $display("FAIL rand_ready@%0d: got %b want %b", n, rdy(), exp_rdy);
            end
            checks++;
            if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_color, bus.out_src, bus.busy} !==
                {m_ov, m_x, m_y, m_c, m_src, m_ov | m_lock}) begin
                errors++; $display("FAIL rand_out@%0d: got v=%b x=%0d y=%0d c=%0d src=%b busy=%b want %b/%0d/%0d/%0d/%b/%b",
                                   n, bus.out_valid, bus.out_x, bus.out_y, bus.out_color, bus.out_src, bus.busy,
                                   m_ov, m_x, m_y, m_c, m_src, m_ov | m_lock);
            end
            // advance the model across the coming edge
            if (!m_ov || bus.out_ready) begin
                m_ov = (g != 2'd0);
                if (g == 2'd1) begin m_x = bus.fh_x; m_y = bus.fh_y; m_c = bus.fh_color; m_src = g; end
                if (g == 2'd2) begin m_x = bus.fl_x; m_y = bus.fl_y; m_c = bus.fl_color; m_src = g; end
                if (g == 2'd3) begin m_x = bus.rs_x; m_y = bus.rs_y; m_c = bus.rs_color; m_src = g; end
            end
            if (!bus.fh_valid || g == 2'd1) m_cnt = 0;
            else if (!m_lock && m_cnt < LIMIT) m_cnt = m_cnt + 1;
            if (g == 2'd2) m_lock = !bus.fl_last;
            fh_pend = bus.fh_valid && (g != 2'd1);
            fl_pend = bus.fl_valid && (g != 2'd2);
            rs_pend = bus.rs_valid && (g != 2'd3);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        bus.out_ready = 1'b1;
        test_reset();
        test_single_freehand();
        test_fill_burst();
        test_priority();
        test_starvation();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_arbiter.md
Name: pixel_arbiter

Overview:
Shares the single pixel-write path (packet generator input and host readout) between three requesters: freehand cursor strokes, rectangle-fill bursts and undo/redo restores. It grants one beat per accept using fixed priority, burst locking for fills and starvation protection for freehand. Granted beats go into a one-entry registered output stage with a valid/ready handshake. It sits between the fill_draw, undo_redo and freehand trigger logic and packet_generator.

Parameters:
COORD_W, 8, width of x/y coordinates
COLOR_W, 3, width of colour field
STARVE_LIMIT, 15, consecutive stalled cycles after which freehand wins priority (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
fh_valid  input  1  freehand beat offered
fh_ready  output  1  freehand beat accepted this cycle
fh_x, fh_y  input  COORD_W  freehand coordinates
fh_color  input  COLOR_W  freehand colour
fl_valid  input  1  fill beat offered
fl_ready  output  1  fill beat accepted this cycle
fl_x, fl_y  input  COORD_W  fill coordinates
fl_color  input  COLOR_W  fill colour
fl_last  input  1  final beat of fill burst
rs_valid  input  1  restore beat offered
rs_ready  output  1  restore beat accepted this cycle
rs_x, rs_y  input  COORD_W  restore coordinates
rs_color  input  COLOR_W  restore colour
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output beat
out_x, out_y  output  COORD_W  granted coordinates
out_color  output  COLOR_W  granted colour
out_src  output  2  source of out beat: 01 freehand, 10 fill, 11 restore
busy  output  1  out_valid OR state==FILL_LOCK

Behaviour:
- Reset (async, rst=1): out_valid=0, out_x/out_y/out_color=0, out_src=00, state=IDLE, starve_cnt=0. All *_ready are 0 while rst=1.
- load_en = !out_valid || out_ready. At most one *_ready is high per cycle. A *_ready is high only when load_en=1 and that requester's valid is 1 and it wins arbitration. *_ready is combinational from the valids, state, starve_cnt and out_ready.
- Accept (valid && ready): the payload is registered into the output stage. out_valid=1 on the next edge, so latency is 1 cycle. With out_ready held high, throughput is 1 beat/cycle.
- While out_valid && !out_ready, out_x/out_y/out_color/out_src stay stable. If out_ready=1 and no accept occurs, out_valid drops to 0. out_src returns to 00 only on reset.
- The FSM has two states, IDLE and FILL_LOCK.
- IDLE priority, high to low:
  1. freehand, if starve_cnt==STARVE_LIMIT
  2. restore
  3. fill
  4. freehand
- IDLE -> FILL_LOCK on a fill accept with fl_last=0. A fill accept with fl_last=1 stays in IDLE (single-beat burst).
- FILL_LOCK: only fill can be granted; fh_ready=rs_ready=0. FILL_LOCK -> IDLE on a fill accept with fl_last=1. Gaps in fl_valid keep the lock and do not release it.
- starve_cnt: cleared when fh_valid=0 or on a freehand accept. Incremented, saturating at STARVE_LIMIT, each IDLE cycle with fh_valid=1 and no freehand accept. Held constant in FILL_LOCK.
- Simultaneous events: all three valids with starve_cnt<limit grant restore. Output stall with pending valids grants nothing and leaves starve_cnt counting.
- Requesters must hold payload stable while valid && !ready. The arbiter does not check this.
- Reset mid-burst: state returns to IDLE and any unaccepted or in-flight output beat is discarded.

Test Plan:
- Reset then idle: rst pulse, no valids -> out_valid=0, out_src=00, busy=0, all readies 0.
- Single freehand (10,20,colour 5), out_ready=1 -> fh_ready 1 cycle; next cycle out_valid=1, out_x=10, out_y=20, out_color=5, out_src=01.
- Fill burst of 4 beats (last on 4th) with rs_valid raised at beat 2 -> 4 consecutive fill beats out, out_src=10. Restore is granted only on the cycle after fl_last accept. busy is high throughout.
- Priority: fh, fl, rs valid together in IDLE -> restore first, then fill (if single-beat), then freehand.
- Starvation, STARVE_LIMIT=3: rs_valid held high with a beat every cycle, fh_valid high -> freehand granted once starve_cnt hits 3, i.e. in the 4th cycle of waiting. starve_cnt then resets and restore resumes.
- Backpressure: out_ready=0 for 5 cycles with beat held -> out payload constant, no readies. Release -> next beat accepted the same cycle out_ready rises. rst asserted mid-FILL_LOCK -> out_valid=0, fh_ready reachable next cycle.
